// File: rtl/sd_spi_master_pkg.sv
// Shared definitions for the SD-card SPI master: register map, status bits, FSM encoding.
package sd_spi_master_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned STRB_W = 4;

    localparam logic [ADDR_W-1:0] REG_DATA   = 6'h00;
    localparam logic [ADDR_W-1:0] REG_STATUS = 6'h01;
    localparam logic [ADDR_W-1:0] REG_DIV    = 6'h02;
    localparam logic [ADDR_W-1:0] REG_CTRL   = 6'h03;

    localparam int unsigned ST_BUSY = 7;
    localparam int unsigned ST_DONE = 6;
    localparam int unsigned ST_WCOL = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2
    } state_t;

endpackage

// File: rtl/sd_spi_master_if.sv
// Peripheral register bus shared by the I/O-controller blocks.
interface sd_spi_master_if;
    import sd_spi_master_pkg::*;

    logic [DATA_W-1:0] data_out;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] addr;
    logic              cs;
    logic              oe;
    logic [STRB_W-1:0] wstrb;

    modport master (output data_in, addr, cs, oe, wstrb, input data_out);
    modport slave  (input data_in, addr, cs, oe, wstrb, output data_out);
endinterface

// File: rtl/sd_spi_master_spi_clkgen.sv
// Half-period divider: counts DIV..0 and pulses rise/fall on the terminal count.
module sd_spi_master_spi_clkgen #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             load,
    input  logic             run,
    input  logic             phase_high,
    input  logic [DIV_W-1:0] div,
    output logic             rise_c,
    output logic             fall_c
);

    logic [DIV_W-1:0] cnt;
    logic             tick_c;

    // Terminal count of the current half-period.
    assign tick_c = run && (cnt == '0);
    assign rise_c = tick_c && !phase_high;
    assign fall_c = tick_c && phase_high;

    // Reload from DIV only at start or terminal count, so a DIV write never cuts a half-period short.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (load || tick_c) begin
            cnt <= div;
        end else if (run) begin
            cnt <= cnt - DIV_W'(1);
        end
    end

endmodule

// File: rtl/sd_spi_master.sv
// Byte-wide mode-0 SPI master for the SD card with a small register interface.
module sd_spi_master
    import sd_spi_master_pkg::*;
#(
    parameter int unsigned      DIV_W   = 8,
    parameter logic [DIV_W-1:0] DIV_RST = DIV_W'(99)
) (
    input  logic                  clk,
    input  logic                  nrst,
    sd_spi_master_if.slave        bus,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    output logic                  spi_cs_n,
    output logic                  irq
);

    state_t           state;
    logic [DIV_W-1:0] div;
    logic [7:0]       sh;
    logic [7:0]       rx_data;
    logic [2:0]       bitn;
    logic             s;
    logic             busy;
    logic             done;
    logic             wcol;
    logic             ie;

    logic             wr_c;
    logic             rd_c;
    logic             start_c;
    logic             wcol_set_c;
    logic             rd_data_c;
    logic             rd_status_c;
    logic             wr_div_c;
    logic             wr_ctrl_c;
    logic             rise_c;
    logic             fall_c;
    logic             last_c;
    logic             done_nxt_c;
    logic             ie_nxt_c;
    logic [7:0]       status_c;
    logic             unused_c;

    // Bus strobes; only the low byte lane is implemented.
    assign wr_c        = bus.cs && bus.wstrb[0];
    assign rd_c        = nrst && bus.cs && bus.oe;
    assign start_c     = wr_c && (bus.addr == REG_DATA) && (state == S_IDLE);
    assign wcol_set_c  = wr_c && (bus.addr == REG_DATA) && (state != S_IDLE);
    assign wr_div_c    = wr_c && (bus.addr == REG_DIV);
    assign wr_ctrl_c   = wr_c && (bus.addr == REG_CTRL);
    assign rd_data_c   = rd_c && (bus.addr == REG_DATA);
    assign rd_status_c = rd_c && (bus.addr == REG_STATUS);
    assign unused_c    = ^{bus.data_in[DATA_W-1:8], bus.wstrb[STRB_W-1:1]};

    // Completion sets done with priority over any clearing read in the same cycle.
    assign last_c     = fall_c && (state == S_HIGH) && (bitn == 3'd7);
    assign done_nxt_c = last_c || (done && !(rd_data_c || start_c));
    assign ie_nxt_c   = wr_ctrl_c ? bus.data_in[1] : ie;

    sd_spi_master_spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
        .clk        (clk),
        .nrst       (nrst),
        .load       (start_c),
        .run        (state != S_IDLE),
        .phase_high (state == S_HIGH),
        .div        (div),
        .rise_c     (rise_c),
        .fall_c     (fall_c)
    );

    // Status byte assembly.
    always_comb begin
        status_c          = '0;
        status_c[ST_BUSY] = busy;
        status_c[ST_DONE] = done;
        status_c[ST_WCOL] = wcol;
    end

    // Register read mux; zero when not selected for read.
    always_comb begin
        bus.data_out = '0;
        if (rd_c) begin
            case (bus.addr)
                REG_DATA:   bus.data_out = DATA_W'(rx_data);
                REG_STATUS: bus.data_out = DATA_W'(status_c);
                REG_DIV:    bus.data_out = DATA_W'(div);
                REG_CTRL:   bus.data_out = DATA_W'({ie, spi_cs_n});
                default:    bus.data_out = '0;
            endcase
        end
    end

    // Transfer FSM, registered pins and software-visible registers.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state    <= S_IDLE;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b1;
            spi_cs_n <= 1'b1;
            irq      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wcol     <= 1'b0;
            ie       <= 1'b0;
            rx_data  <= '0;
            div      <= DIV_RST;
            sh       <= '0;
            bitn     <= '0;
            s        <= 1'b0;
        end else begin
            done <= done_nxt_c;
            ie   <= ie_nxt_c;
            irq  <= done_nxt_c && ie_nxt_c;

            if (wr_div_c) begin
                div <= DIV_W'(bus.data_in[7:0]);
            end
            if (wr_ctrl_c) begin
                spi_cs_n <= bus.data_in[0];
            end
            if (wcol_set_c) begin
                wcol <= 1'b1;
            end else if (rd_status_c) begin
                wcol <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start_c) begin
                        sh       <= bus.data_in[7:0];
                        spi_mosi <= bus.data_in[7];
                        bitn     <= '0;
                        busy     <= 1'b1;
                        state    <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (rise_c) begin
                        spi_sck <= 1'b1;
                        s       <= spi_miso;
                        state   <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (fall_c) begin
                        spi_sck <= 1'b0;
                        if (bitn == 3'd7) begin
                            rx_data  <= {sh[6:0], s};
                            busy     <= 1'b0;
                            spi_mosi <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            sh       <= {sh[6:0], s};
                            spi_mosi <= sh[6];
                            bitn     <= bitn + 3'd1;
                            state    <= S_LOW;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_master.sv
// Scoreboard bench for sd_spi_master: driver queues expectations, monitor checks reads and SPI frames.
module tb_sd_spi_master;
    import sd_spi_master_pkg::*;

    typedef struct {
        logic [7:0]  tx;
        int unsigned div;
        int unsigned start;
        logic        irq;
    } xfer_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    sd_spi_master_if bus();
    logic spi_sck, spi_mosi, spi_miso, spi_cs_n, irq;

    logic        loop = 1'b1;
    logic [7:0]  mbyte = 8'h00;
    int unsigned rises = 0;
    int unsigned cyc = 0;
    int unsigned total = 0;
    int unsigned bad = 0;

    int unsigned cur_div = 99;
    logic        cur_ie = 1'b0;
    logic [7:0]  last_rx = 8'h00;

    xfer_t       xq[$];
    logic [31:0] rq[$];
    string       rnq[$];

    sd_spi_master #(.DIV_W(8), .DIV_RST(8'd99)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .bus      (bus),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_cs_n (spi_cs_n),
        .irq      (irq)
    );

    // Card model: loopback or a byte presented MSB first, advancing after each SCK rise.
    logic [2:0] midx;
    always_comb begin
        midx     = (rises > 7) ? 3'd0 : 3'(7 - rises);
        spi_miso = loop ? spi_mosi : mbyte[midx];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: checks every bus read and every completed SPI frame against queued expectations.
    logic        prev_sck = 1'b0;
    logic        tim_ok = 1'b1;
    logic [7:0]  mosi_acc = 8'h00;
    int unsigned last_edge = 0;
    always @(negedge clk) begin
        if (!nrst) begin
            rises    = 0;
            prev_sck = 1'b0;
            xq.delete();
        end else begin
            if (bus.cs && bus.oe) begin
                if (rq.size() == 0) begin
                    chk("unexpected_read", bus.data_out, 32'hxxxx_xxxx);
                end else begin
                    chk(rnq.pop_front(), bus.data_out, rq.pop_front());
                end
            end
            if (spi_sck && !prev_sck) begin
                if (xq.size() == 0) begin
                    chk("sck_without_xfer", 32'(rises), 32'hffff_ffff);
                end else begin
                    if (rises == 0) tim_ok = ((cyc - xq[0].start) == xq[0].div + 1);
                    else            tim_ok = tim_ok && ((cyc - last_edge) == xq[0].div + 1);
                    mosi_acc  = {mosi_acc[6:0], spi_mosi};
                    rises     = rises + 1;
                    last_edge = cyc;
                end
            end else if (!spi_sck && prev_sck && xq.size() != 0) begin
                tim_ok    = tim_ok && ((cyc - last_edge) == xq[0].div + 1);
                last_edge = cyc;
                if (rises == 8) begin
                    xfer_t x;
                    x = xq.pop_front();
                    chk("mosi_byte", 32'(mosi_acc), 32'(x.tx));
                    chk("sck_half_periods", 32'(tim_ok), 32'd1);
                    chk("busy_cycles", cyc - x.start, 16 * (x.div + 1));
                    chk("irq_at_done", 32'(irq), 32'(x.irq));
                    rises = 0;
                end
            end
            prev_sck = spi_sck;
        end
    end

    task automatic bus_write(input logic [5:0] a, input logic [7:0] d, output int unsigned acc);
        @(posedge clk); #1;
        bus.cs      = 1'b1;
        bus.wstrb   = 4'h1;
        bus.addr    = a;
        bus.data_in = {24'($urandom), d};
        @(posedge clk); #1;
        acc       = cyc;
        bus.cs    = 1'b0;
        bus.wstrb = 4'h0;
    endtask

    task automatic read_now(input logic [5:0] a, input logic [31:0] exp, input string name);
        rq.push_back(exp);
        rnq.push_back(name);
        bus.cs   = 1'b1;
        bus.oe   = 1'b1;
        bus.addr = a;
        @(posedge clk); #1;
        bus.cs = 1'b0;
        bus.oe = 1'b0;
    endtask

    task automatic bus_read(input logic [5:0] a, input logic [31:0] exp, input string name);
        @(posedge clk); #1;
        read_now(a, exp, name);
    endtask

    // Read whose side-effect edge is exactly cycle 'target'.
    task automatic bus_read_at(input logic [5:0] a, input logic [31:0] exp, input string name,
                               input int unsigned target);
        int n = 0;
        while (cyc + 1 < target && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_align"}, cyc + 1, target);
        read_now(a, exp, name);
    endtask

    task automatic set_div(input int unsigned d);
        int unsigned acc;
        bus_write(REG_DIV, 8'(d), acc);
        cur_div = d;
    endtask

    task automatic set_ctrl(input logic cs_n, input logic ien);
        int unsigned acc;
        bus_write(REG_CTRL, {6'b0, ien, cs_n}, acc);
        cur_ie = ien;
    endtask

    task automatic start_xfer(input logic [7:0] tx, input logic [7:0] mb, input logic lp,
                              output int unsigned acc);
        xfer_t x;
        loop  = lp;
        mbyte = mb;
        bus_write(REG_DATA, tx, acc);
        x.tx = tx; x.div = cur_div; x.start = acc; x.irq = cur_ie;
        xq.push_back(x);
        last_rx = lp ? tx : mb;
    endtask

    task automatic wait_done(input int unsigned budget);
        int unsigned n = 0;
        while (xq.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("xfer_timeout", 32'(xq.size()), 32'd0);
        #1;
    endtask

    initial begin
        int unsigned acc;
        bus.cs = 1'b0; bus.oe = 1'b0; bus.wstrb = 4'h0; bus.addr = '0; bus.data_in = '0;
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sck", 32'(spi_sck), 32'd0);
        chk("rst_mosi", 32'(spi_mosi), 32'd1);
        chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);
        nrst = 1'b1;
        bus_read(REG_STATUS, 32'h00, "rst_status");
        bus_read(REG_DIV, 32'd99, "rst_div");
        bus_read(REG_CTRL, 32'h01, "rst_ctrl");
        bus_read(REG_DATA, 32'h00, "rst_data");
        bus_read(6'h3f, 32'h00, "unmapped_read");

        // Loopback at the fastest rate.
        set_div(0);
        start_xfer(8'hA5, 8'h00, 1'b1, acc);
        bus_read(REG_STATUS, 32'h80, "loop_status_busy");
        wait_done(200);
        bus_read(REG_STATUS, 32'h40, "loop_status_done");
        bus_read(REG_DATA, 32'hA5, "loop_rx");
        bus_read(REG_STATUS, 32'h00, "loop_status_clr");

        // Slower divider with MISO held low.
        set_div(3);
        bus_read(REG_DIV, 32'd3, "div_readback");
        start_xfer(8'hFF, 8'h00, 1'b0, acc);
        wait_done(400);
        bus_read(REG_DATA, 32'h00, "div3_rx");

        // Write collision; STATUS read landing on completion clears wcol but keeps done.
        start_xfer(8'h3C, 8'($urandom), 1'b0, acc);
        repeat (3) @(posedge clk);
        begin
            int unsigned dummy;
            bus_write(REG_DATA, 8'h11, dummy);
        end
        bus_read_at(REG_STATUS, 32'hA0, "wcol_status", acc + 16 * (cur_div + 1));
        wait_done(400);
        bus_read(REG_STATUS, 32'h40, "wcol_cleared");
        bus_read(REG_DATA, 32'(last_rx), "wcol_rx");
        bus_read(REG_STATUS, 32'h00, "wcol_status_clr");

        // Interrupt, and a DATA read coinciding with completion.
        set_ctrl(1'b0, 1'b1);
        start_xfer(8'h00, 8'hFF, 1'b0, acc);
        wait_done(400);
        chk("irq_after_done", 32'(irq), 32'd1);
        bus_read(REG_STATUS, 32'h40, "irq_status");
        begin
            logic [7:0] prev_rx;
            prev_rx = last_rx;
            start_xfer(8'($urandom), 8'($urandom), 1'b0, acc);
            bus_read_at(REG_DATA, 32'(prev_rx), "coincident_rd", acc + 16 * (cur_div + 1));
        end
        wait_done(400);
        chk("irq_kept", 32'(irq), 32'd1);
        bus_read(REG_STATUS, 32'h40, "done_kept");
        bus_read(REG_DATA, 32'(last_rx), "irq_rx2");
        chk("irq_cleared", 32'(irq), 32'd0);
        bus_read(REG_STATUS, 32'h00, "irq_status_clr");

        // Software chip select.
        set_ctrl(1'b0, 1'b0);
        chk("cs_n_low", 32'(spi_cs_n), 32'd0);
        bus_read(REG_STATUS, 32'h00, "cs_idle_status");
        set_ctrl(1'b1, 1'b0);
        chk("cs_n_high", 32'(spi_cs_n), 32'd1);

        // Randomised transfers.
        for (int i = 0; i < 5; i++) begin
            set_div($urandom_range(0, 2));
            start_xfer(8'($urandom), 8'($urandom), 1'($urandom), acc);
            wait_done(200);
            bus_read(REG_DATA, 32'(last_rx), "rand_rx");
            bus_read(REG_STATUS, 32'h00, "rand_status");
        end

        // Reset in the middle of a transfer.
        set_ctrl(1'b0, 1'b1);
        set_div(5);
        start_xfer(8'h5A, 8'h00, 1'b0, acc);
        repeat (30) @(posedge clk);
        #1;
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_sck", 32'(spi_sck), 32'd0);
        chk("mid_rst_mosi", 32'(spi_mosi), 32'd1);
        chk("mid_rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("mid_rst_irq", 32'(irq), 32'd0);
        nrst = 1'b1;
        bus_read(REG_STATUS, 32'h00, "mid_rst_status");
        bus_read(REG_DIV, 32'd99, "mid_rst_div");
        bus_read(REG_CTRL, 32'h01, "mid_rst_ctrl");
        repeat (4) @(posedge clk);
        chk("reads_pending", 32'(rq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
